// File: rtl/cmd_status_arbiter.sv
// Round-robin arbiter that shares one command/status bus among N_REQ requesters.
// Only one transaction is in flight. A status timeout forces an ERROR status back to the requester.
module cmd_status_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_cmd_valid,
  output logic [N_REQ-1:0]              o_cmd_ready,
  input  logic [N_REQ-1:0]              i_cmd,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_cmd_data,
  output logic [N_REQ-1:0]              o_sts_valid,
  input  logic [N_REQ-1:0]              i_sts_ready,
  output logic                          o_sts,
  output logic                          o_bus_command_valid,
  input  logic                          i_bus_command_ready,
  output logic                          o_bus_command,
  output logic [DATA_WIDTH-1:0]         o_bus_data,
  input  logic                          i_bus_status_valid,
  output logic                          o_bus_status_ready,
  input  logic                          i_bus_status,
  output logic                          o_busy,
  output logic [$clog2(N_REQ)-1:0]      o_grant_id,
  output logic                          o_timeout
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_STS, RETURN} state_t;

  state_t                state, state_next;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         pick, cand;
  logic                  found;
  logic [DATA_WIDTH-1:0] pick_data;
  logic [TW-1:0]         timer;
  logic                  timer_done;
  logic                  cmd_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign timer_done    = (timer == TW'(TIMEOUT - 1));
  assign o_busy        = (state != IDLE);
  assign o_bus_command = cmd_q;
  assign o_bus_data    = data_q;

  // Scan from the requester after the last one served, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    found     = 1'b0;
    pick      = '0;
    cand      = '0;
    pick_data = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % N_REQ);
      if (!found && i_cmd_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    for (int r = 0; r < N_REQ; r++) begin
      if (pick == GW'(r)) pick_data = i_cmd_data[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_next          = state;
    o_cmd_ready         = '0;
    o_sts_valid         = '0;
    o_bus_command_valid = 1'b0;
    o_bus_status_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        o_bus_status_ready = 1'b1;
        // A requester is never told "accepted" while reset is discarding the handshake.
        if (found && i_rst) begin
          o_cmd_ready[pick] = 1'b1;
          state_next        = ISSUE;
        end
      end
      ISSUE: begin
        o_bus_command_valid = 1'b1;
        if (i_bus_command_ready) state_next = WAIT_STS;
      end
      WAIT_STS: begin
        o_bus_status_ready = 1'b1;
        if (i_bus_status_valid || timer_done) state_next = RETURN;
      end
      RETURN: begin
        o_bus_status_ready      = 1'b1;
        o_sts_valid[o_grant_id] = 1'b1;
        if (i_sts_ready[o_grant_id]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_rst) begin
      state      <= IDLE;
      last_grant <= GW'(N_REQ - 1);
      o_grant_id <= '0;
      timer      <= '0;
      cmd_q      <= 1'b0;
      data_q     <= '0;
      o_sts      <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state     <= state_next;
      o_timeout <= 1'b0;
      unique case (state)
        IDLE: if (found) begin
          cmd_q      <= i_cmd[pick];
          data_q     <= pick_data;
          o_grant_id <= pick;
        end
        ISSUE: if (i_bus_command_ready) timer <= '0;
        WAIT_STS: begin
          // A real status beats a timeout that expires in the same cycle.
          if (i_bus_status_valid) begin
            o_sts <= i_bus_status;
          end else if (timer_done) begin
            o_sts     <= 1'b1;
            o_timeout <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RETURN: if (i_sts_ready[o_grant_id]) last_grant <= o_grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_status_arbiter.sv
// Self-checking bench for cmd_status_arbiter. A negedge reference model pushes the expected
// bus commands and statuses to scoreboards, then checks them when the DUT presents them.
module tb_cmd_status_arbiter;
  localparam int N_REQ   = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;
  localparam int GW      = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N_REQ-1:0]    cmd_valid = '0, cmd = '0, sts_ready = '1;
  logic [N_REQ-1:0]    cmd_ready, sts_valid;
  logic [N_REQ*DW-1:0] cmd_data = '0;
  logic bus_cmd_ready = 1'b0, bus_sts_valid = 1'b0, bus_sts = 1'b0;
  logic sts, bus_cmd_valid, bus_cmd, bus_sts_ready, busy, timeout;
  logic [DW-1:0] bus_data;
  logic [GW-1:0] grant_id;

  always #5 clk = ~clk;

  cmd_status_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd(cmd), .i_cmd_data(cmd_data),
    .o_sts_valid(sts_valid), .i_sts_ready(sts_ready), .o_sts(sts),
    .o_bus_command_valid(bus_cmd_valid), .i_bus_command_ready(bus_cmd_ready),
    .o_bus_command(bus_cmd), .o_bus_data(bus_data),
    .i_bus_status_valid(bus_sts_valid), .o_bus_status_ready(bus_sts_ready), .i_bus_status(bus_sts),
    .o_busy(busy), .o_grant_id(grant_id), .o_timeout(timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct { logic c; logic [DW-1:0] d; } bus_exp_t;
  bus_exp_t      bus_q[$];
  logic          sts_q[$];
  logic [GW-1:0] grant_log[$];

  int            m_phase = 0;
  logic [GW-1:0] m_last  = GW'(N_REQ - 1);
  logic [GW-1:0] m_grant = '0;
  int            m_timer = 0;
  logic          m_tmo   = 1'b0;
  logic [N_REQ-1:0] hs_mask = '0;
  logic [N_REQ-1:0] cont    = '0;
  int cyc = 0, n_done = 0, cmd_hs_cyc = 0, last_rt = 0, wait_entry = 0, tmo_lat = -1;

  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] v);
    for (int k = 1; k <= N_REQ; k++) if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  // Reference model: checks current outputs, then advances to the post-edge state.
  always @(negedge clk) begin : model
    int   g;
    logic tmo_n;
    cyc++;
    hs_mask = '0;
    tmo_n   = 1'b0;
    if (rst) begin
      check("grant_id", grant_id, m_grant);
      check("busy", busy, m_phase != 0);
      check("timeout", timeout, m_tmo);
      if (timeout) tmo_lat = cyc - wait_entry;
      case (m_phase)
        0: begin
          g = rr_pick(int'(m_last), cmd_valid);
          check("cmd_ready", cmd_ready, (g < 0) ? 0 : (1 << g));
          check("idle_sts_valid", sts_valid, 0);
          check("idle_bus_cmd_valid", bus_cmd_valid, 0);
          check("idle_bus_sts_ready", bus_sts_ready, 1);
          if (g >= 0) begin
            bus_q.push_back('{cmd[g], cmd_data[g*DW +: DW]});
            grant_log.push_back(GW'(g));
            m_grant    = GW'(g);
            hs_mask[g] = 1'b1;
            cmd_hs_cyc = cyc;
            m_phase    = 1;
          end
        end
        1: begin
          check("issue_cmd_ready", cmd_ready, 0);
          check("issue_bus_cmd_valid", bus_cmd_valid, 1);
          check("issue_bus_sts_ready", bus_sts_ready, 0);
          check("bus_q_size", bus_q.size(), 1);
          if (bus_q.size() > 0) begin
            check("bus_cmd", bus_cmd, bus_q[0].c);
            check("bus_data", bus_data, bus_q[0].d);
            if (bus_cmd_ready) void'(bus_q.pop_front());
          end
          if (bus_cmd_ready) begin
            m_phase    = 2;
            m_timer    = 0;
            wait_entry = cyc + 1;
          end
        end
        2: begin
          check("wait_cmd_ready", cmd_ready, 0);
          check("wait_bus_cmd_valid", bus_cmd_valid, 0);
          check("wait_bus_sts_ready", bus_sts_ready, 1);
          check("wait_sts_valid", sts_valid, 0);
          if (bus_sts_valid) begin
            sts_q.push_back(bus_sts);
            m_phase = 3;
          end else if (m_timer == TIMEOUT - 1) begin
            sts_q.push_back(1'b1);
            tmo_n   = 1'b1;
            m_phase = 3;
          end else begin
            m_timer++;
          end
        end
        default: begin
          check("ret_cmd_ready", cmd_ready, 0);
          check("ret_bus_cmd_valid", bus_cmd_valid, 0);
          check("ret_bus_sts_ready", bus_sts_ready, 1);
          check("sts_valid", sts_valid, 1 << m_grant);
          check("sts_q_size", sts_q.size(), 1);
          if (sts_q.size() > 0) begin
            check("sts", sts, sts_q[0]);
            if (sts_ready[m_grant]) void'(sts_q.pop_front());
          end
          if (sts_ready[m_grant]) begin
            m_last  = m_grant;
            m_phase = 0;
            last_rt = cyc - cmd_hs_cyc;
            n_done++;
          end
        end
      endcase
    end
    m_tmo = tmo_n;
    if (!rst) begin
      m_phase = 0;
      m_last  = GW'(N_REQ - 1);
      m_grant = '0;
      m_timer = 0;
      m_tmo   = 1'b0;
      bus_q.delete();
      sts_q.delete();
    end
  end

  // Requesters drop valid once accepted unless configured as continuous.
  initial forever begin
    @(posedge clk);
    #1;
    cmd_valid = cmd_valid & ~(hs_mask & ~cont);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic post(input int r, input logic c, input logic [DW-1:0] d);
    cmd[r]             = c;
    cmd_data[r*DW +: DW] = d;
    cmd_valid[r]       = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (n_done < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, n_done >= target, 1);
  endtask

  task automatic wait_phase(input int p, input int budget, input string tag);
    int k = 0;
    while (m_phase != p && k < budget) begin
      tick();
      k++;
    end
    check(tag, m_phase, p);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_cmd_ready"}, cmd_ready, 0);
    check({pfx, "_sts_valid"}, sts_valid, 0);
    check({pfx, "_bus_cmd_valid"}, bus_cmd_valid, 0);
    check({pfx, "_bus_cmd"}, bus_cmd, 0);
    check({pfx, "_bus_data"}, bus_data, 0);
    check({pfx, "_sts"}, sts, 0);
    check({pfx, "_timeout"}, timeout, 0);
    check({pfx, "_grant_id"}, grant_id, 0);
  endtask

  initial begin
    int base;
    int k;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b1;
    tick();

    // Single READ from req1 with an immediately ready bus and status.
    bus_cmd_ready = 1'b1;
    bus_sts_valid = 1'b1;
    bus_sts       = 1'b0;
    base = n_done;
    post(1, 1'b1, 8'hA5);
    wait_done(base + 1, 20, "single_done");
    check("single_rt", last_rt, 3);
    check("single_grant", grant_id, 1);

    // Round robin from a fresh reset: all requesters continuously valid.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    grant_log.delete();
    base = n_done;
    cont = '1;
    for (int r = 0; r < N_REQ; r++) post(r, r[0], DW'(16 + r));
    wait_done(base + 5, 60, "rr_done");
    cmd_valid = '0;
    cont      = '0;
    wait_phase(0, 20, "rr_idle");
    check("rr_count", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5)
      for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), grant_log[i], i % N_REQ);

    // Silent slave: timeout forces ERROR, then a late status in IDLE is dropped.
    bus_sts_valid = 1'b0;
    base    = n_done;
    tmo_lat = -1;
    post(2, 1'b0, 8'h3C);
    wait_done(base + 1, 40, "tmo_done");
    check("tmo_lat", tmo_lat, TIMEOUT);
    bus_sts_valid = 1'b1;
    bus_sts       = 1'b0;
    base = n_done;
    repeat (3) tick();
    check("late_no_txn", n_done, base);
    check("late_busy", busy, 0);
    bus_sts_valid = 1'b0;

    // Backpressure on both the bus command and the requester status.
    grant_log.delete();
    bus_cmd_ready = 1'b0;
    bus_sts_valid = 1'b1;
    bus_sts       = 1'b1;
    sts_ready[0]  = 1'b0;
    base = n_done;
    post(0, 1'b1, 8'h5A);
    tick();
    cmd_data[DW-1:0] = 8'hFF;
    post(1, 1'b0, 8'h11);
    post(3, 1'b1, 8'h33);
    repeat (5) tick();
    bus_cmd_ready = 1'b1;
    wait_phase(3, 10, "bp_return");
    repeat (3) tick();
    sts_ready = '1;
    wait_done(base + 3, 40, "bp_done");
    check("bp_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("bp_grant0", grant_log[0], 0);
      check("bp_grant1", grant_log[1], 1);
      check("bp_grant2", grant_log[2], 3);
    end

    // Status ERROR arrives on the last timer cycle: real status wins, no timeout pulse.
    bus_sts_valid = 1'b0;
    base    = n_done;
    tmo_lat = -1;
    post(3, 1'b1, 8'hC3);
    wait_phase(2, 10, "col_wait");
    k = 0;
    while (m_timer != TIMEOUT - 1 && k < 40) begin
      tick();
      k++;
    end
    check("col_timer", m_timer, TIMEOUT - 1);
    bus_sts_valid = 1'b1;
    bus_sts       = 1'b1;
    tick();
    bus_sts_valid = 1'b0;
    wait_done(base + 1, 10, "col_done");
    check("col_no_timeout", tmo_lat, -1);

    // Reset while waiting for status, then req0 must win first.
    post(1, 1'b0, 8'h77);
    wait_phase(2, 10, "rm_wait");
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("rm");
    rst = 1'b1;
    grant_log.delete();
    bus_sts_valid = 1'b1;
    bus_sts       = 1'b0;
    base = n_done;
    post(2, 1'b1, 8'h22);
    post(0, 1'b0, 8'h0F);
    wait_done(base + 2, 30, "rm_done");
    check("rm_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("rm_first_grant", grant_log[0], 0);
      check("rm_second_grant", grant_log[1], 2);
    end

    repeat (2) tick();
    check("bus_q_empty", bus_q.size(), 0);
    check("sts_q_empty", sts_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
